// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers (shift-add multiply, restoring divide).
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_WRITE_EN.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef MULDIV_HILO_WRITE_EN
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_data_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand conditioning at accept: magnitudes for signed ops
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg  = op_i[0] & a_i[WIDTH-1];
  assign b_neg  = op_i[0] & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign b_zero = (b_i == '0);

  // One shift-add multiply step: acc holds {partial_product, remaining_multiplier}
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: acc holds {remainder, quotient/dividend}
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_next  = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix applied in the final cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
`ifdef MULDIV_HILO_WRITE_EN
        if (wr_hi_i) hi_d = wr_data_i;
        if (wr_lo_i) lo_d = wr_data_i;
`endif
        if (start_i) begin
          cnt_d    = '0;
          dbz_d    = 1'b0;
          is_div_d = op_i[1];
          neg_lo_d = a_neg ^ b_neg;
          div0_d   = op_i[1] & b_zero;
          if (op_i[1]) begin
            neg_hi_d = a_neg;
            opnd_d   = b_mag;
            if (b_zero) begin
              // Raw A is kept so the divide-by-zero result reports it unmodified
              acc_d   = {a_i, {WIDTH{1'b0}}};
              state_d = S_FIX;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              state_d = S_RUN;
            end
          end else begin
            neg_hi_d = 1'b0;
            opnd_d   = a_mag;
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (div0_q) begin
          hi_d  = acc_q[2*WIDTH-1:WIDTH];
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32 and WIDTH=8 instances).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

`ifdef MULDIV_HILO_WRITE_EN
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        wr_hi8, wr_lo8;
  logic [7:0]  wr_data8;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int lat, bcyc, ndone;
  logic [31:0] hmid;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
`ifdef MULDIV_HILO_WRITE_EN
    .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data),
`endif
    .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
  );

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
`ifdef MULDIV_HILO_WRITE_EN
    .wr_hi_i(wr_hi8), .wr_lo_i(wr_lo8), .wr_data_i(wr_data8),
`endif
    .busy_o(busy8), .done_o(done8), .div_by_zero_o(dbz8), .hi_o(hi8), .lo_o(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns cycles from accept edge to Done, busy-high samples, and Hi seen mid-run
  task automatic wait_done(output int l, output int bc, output logic [31:0] hm);
    l = 0; bc = 0; hm = 'x;
    while (done !== 1'b1 && l < 100) begin
      if (busy === 1'b1) bc++;
      if (l == 10) hm = hi;
      @(posedge clk); #1;
      l++;
    end
    $display("op=%0d a=0x%08h b=0x%08h lat=%0d hi=0x%08h lo=0x%08h dbz=%0b", op, a, b, l, hi, lo, dbz);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int l);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    l = 0;
    while (done8 !== 1'b1 && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
    $display("w8 op=%0d a=0x%02h b=0x%02h lat=%0d hi=0x%02h lo=0x%02h", o, x, y, l, hi8, lo8);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
`ifdef MULDIV_HILO_WRITE_EN
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    wr_hi8 = 1'b0; wr_lo8 = 1'b0; wr_data8 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz",  64'(dbz),  64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // MULTU max * max
    accept(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcyc, hmid);
    check("multu_lat",   64'(lat),  64'd33);
    check("multu_busyc", 64'(bcyc), 64'd33);
    check("multu_busy0", 64'(busy), 64'd0);
    check("multu_hi",    64'(hi),   64'hFFFF_FFFE);
    check("multu_lo",    64'(lo),   64'h0000_0001);
    check("multu_hold",  64'(hmid), 64'h0);
    @(posedge clk); #1;
    check("done_pulse",  64'(done), 64'd0);

    // MULT -7 * 6; Hi must hold the previous result while running
    accept(2'b01, 32'hFFFF_FFF9, 32'd6);
    wait_done(lat, bcyc, hmid);
    check("mult_hold", 64'(hmid), 64'hFFFF_FFFE);
    check("mult_hi",   64'(hi),   64'hFFFF_FFFF);
    check("mult_lo",   64'(lo),   64'hFFFF_FFD6);

    accept(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_done(lat, bcyc, hmid);
    check("mult_nn_hi", 64'(hi), 64'h0);
    check("mult_nn_lo", 64'(lo), 64'hF);

    accept(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcyc, hmid);
    check("div_lat", 64'(lat), 64'd33);
    check("div_lo",  64'(lo),  64'hFFFF_FFFD);
    check("div_hi",  64'(hi),  64'hFFFF_FFFF);

    accept(2'b11, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, bcyc, hmid);
    check("div_pn_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_pn_hi", 64'(hi), 64'h1);

    accept(2'b10, 32'd100, 32'd7);
    wait_done(lat, bcyc, hmid);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    // Divide by zero
    accept(2'b10, 32'h1234, 32'd0);
    wait_done(lat, bcyc, hmid);
    check("dz_lat", 64'(lat), 64'd1);
    check("dz_dbz", 64'(dbz), 64'd1);
    check("dz_hi",  64'(hi),  64'h1234);
    check("dz_lo",  64'(lo),  64'hFFFF_FFFF);

    accept(2'b11, 32'hFFFF_FFF0, 32'd0);
    wait_done(lat, bcyc, hmid);
    check("dzs_dbz", 64'(dbz), 64'd1);
    check("dzs_hi",  64'(hi),  64'hFFFF_FFF0);

    accept(2'b10, 32'd9, 32'd2);
    check("dz_clear", 64'(dbz), 64'd0);
    wait_done(lat, bcyc, hmid);
    check("divu2_lo", 64'(lo), 64'd4);
    check("divu2_hi", 64'(hi), 64'd1);

    // Start pulsed mid-run is ignored
    accept(2'b00, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc, hmid);
    check("mid_lat", 64'(lat), 64'd23);
    check("mid_lo",  64'(lo),  64'd15);
    check("mid_hi",  64'(hi),  64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_noqueue", 64'(busy), 64'd0);

    // Start held through Done: second op accepted with no gap
    accept(2'b00, 32'd6, 32'd7);
    start = 1'b1; op = 2'b00; a = 32'h0001_0001; b = 32'h0003_0000;
    wait_done(lat, bcyc, hmid);
    check("b2b1_lat", 64'(lat), 64'd33);
    check("b2b1_lo",  64'(lo),  64'd42);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, bcyc, hmid);
    check("b2b2_lat", 64'(lat), 64'd33);
    check("b2b2_hi",  64'(hi),  64'h3);
    check("b2b2_lo",  64'(lo),  64'h0003_0000);

    // Reset at iteration 10 aborts with no Done
    accept(2'b00, 32'hFFFF_FFFF, 32'd2);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi",   64'(hi),   64'd0);
    check("abort_lo",   64'(lo),   64'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);

    accept(2'b00, 32'h10, 32'h10);
    wait_done(lat, bcyc, hmid);
    check("post_rst_lo", 64'(lo), 64'h100);

    // WIDTH=8 instance
    run8(2'b11, 8'h80, 8'hFF, lat);
    check("w8_ovf_lat", 64'(lat), 64'd9);
    check("w8_ovf_lo",  64'(lo8), 64'h80);
    check("w8_ovf_hi",  64'(hi8), 64'h00);
    run8(2'b01, 8'hFD, 8'h05, lat);
    check("w8_mult_hi", 64'(hi8), 64'hFF);
    check("w8_mult_lo", 64'(lo8), 64'hF1);
    run8(2'b10, 8'd200, 8'd7, lat);
    check("w8_divu_lo", 64'(lo8), 64'h1C);
    check("w8_divu_hi", 64'(hi8), 64'h04);

`ifdef MULDIV_HILO_WRITE_EN
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h55;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("wr_hi_idle", 64'(hi), 64'h55);
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h66;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check("wr_lo_idle", 64'(lo), 64'h66);
    accept(2'b00, 32'd2, 32'd3);
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hAB;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("wr_busy_ign", 64'(hi), 64'h55);
    wait_done(lat, bcyc, hmid);
    check("wr_op_hi", 64'(hi), 64'h0);
    check("wr_op_lo", 64'(lo), 64'h6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
